// File: rtl/irreg_counter_ctrl_if.sv
// Command channel between the test/config host and the irregular-counter sequencer.
// The host drives a command and holds it until the sequencer shows it is ready.
interface irreg_counter_ctrl_if #(
    parameter int STEP_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_seed;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_seed,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_seed,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/irreg_counter_ctrl.sv
// Sequencer and on-line checker for the 3-bit irregular counter: loads a seed, advances
// the counter a commanded number of steps and checks every step against a golden model.
module irreg_counter_ctrl #(
    parameter int STEP_W = 8,
    parameter int ERR_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    irreg_counter_ctrl_if.slave cmd,
    input  logic                abort,
    output logic                cnt_load,
    output logic [2:0]          cnt_load_value,
    output logic                cnt_en,
    input  logic [2:0]          cnt_q,
    output logic                busy,
    output logic                done,
    output logic [2:0]          result,
    output logic                err,
    output logic [ERR_W-1:0]    err_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

    state_t            state_reg;
    logic [STEP_W-1:0] remaining_reg;
    logic [2:0]        seed_reg;
    logic [2:0]        exp_reg;
    logic [ERR_W-1:0]  run_err_reg;
    logic              cmd_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cnt_load_reg;
    logic              cnt_en_reg;
    logic [2:0]        result_reg;
    logic              err_reg;
    logic [ERR_W-1:0]  err_cnt_reg;

    logic              mismatch;
    logic [ERR_W-1:0]  run_err_next;

    // Bit 2 is q0 (MSB), bit 0 is q2.
    function automatic logic [2:0] golden_next(input logic [2:0] q);
        return {~q[2] | q[0], ~q[1], ~q[2] | (q[0] & ~q[1])};
    endfunction

    assign mismatch     = (cnt_q != exp_reg);
    assign run_err_next = (mismatch && (run_err_reg != '1)) ? run_err_reg + ERR_W'(1)
                                                            : run_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            seed_reg      <= '0;
            exp_reg       <= '0;
            run_err_reg   <= '0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cnt_load_reg  <= 1'b0;
            cnt_en_reg    <= 1'b0;
            result_reg    <= '0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            done_reg     <= 1'b0;
            cnt_load_reg <= 1'b0;
            cnt_en_reg   <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        seed_reg      <= cmd.cmd_seed;
                        remaining_reg <= cmd.cmd_steps;
                        run_err_reg   <= '0;
                        cnt_load_reg  <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        exp_reg <= seed_reg;
                        if (remaining_reg == '0) begin
                            state_reg <= CHECK;
                        end else begin
                            state_reg  <= RUN;
                            cnt_en_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        run_err_reg   <= run_err_next;
                        exp_reg       <= golden_next(exp_reg);
                        remaining_reg <= remaining_reg - STEP_W'(1);
                        // cnt_en stays high for every RUN cycle except the transition to CHECK.
                        if (remaining_reg == STEP_W'(1)) begin
                            state_reg <= CHECK;
                        end else begin
                            cnt_en_reg <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end else begin
                        result_reg  <= cnt_q;
                        err_cnt_reg <= run_err_next;
                        err_reg     <= (run_err_next != '0);
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: begin
                    state_reg     <= IDLE;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready   = cmd_ready_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign cnt_load        = cnt_load_reg;
    assign cnt_load_value  = seed_reg;
    assign cnt_en          = cnt_en_reg;
    assign result          = result_reg;
    assign err             = err_reg;
    assign err_cnt         = err_cnt_reg;
endmodule

// File: tb/tb_irreg_counter_ctrl.sv
// Bench for irreg_counter_ctrl: two instances (4-bit and 2-bit error counters) run the
// same commands against a behavioural counter that can be correct or faulty.
module tb_irreg_counter_ctrl;
    localparam int STEP_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mode = 0;              // 0 correct, 1 sticks after first advance, 2 always 010
    logic [2:0] cur_seed = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    irreg_counter_ctrl_if #(.STEP_W(STEP_W)) if_a ();
    irreg_counter_ctrl_if #(.STEP_W(STEP_W)) if_b ();

    logic       cnt_load_a, cnt_en_a, busy_a, done_a, err_a;
    logic [2:0] cnt_load_value_a, result_a;
    logic [3:0] err_cnt_a;
    logic       cnt_load_b, cnt_en_b, busy_b, done_b, err_b;
    logic [2:0] cnt_load_value_b, result_b;
    logic [1:0] err_cnt_b;
    logic [2:0] ctr_a = 3'b000, ctr_b = 3'b000;
    logic       adv_a = 1'b0, adv_b = 1'b0;
    logic [2:0] nxt_tab [8];

    irreg_counter_ctrl #(.STEP_W(STEP_W), .ERR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(if_a.slave), .abort(abort),
        .cnt_load(cnt_load_a), .cnt_load_value(cnt_load_value_a), .cnt_en(cnt_en_a),
        .cnt_q(ctr_a), .busy(busy_a), .done(done_a), .result(result_a),
        .err(err_a), .err_cnt(err_cnt_a)
    );

    irreg_counter_ctrl #(.STEP_W(STEP_W), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(if_b.slave), .abort(abort),
        .cnt_load(cnt_load_b), .cnt_load_value(cnt_load_value_b), .cnt_en(cnt_en_b),
        .cnt_q(ctr_b), .busy(busy_b), .done(done_b), .result(result_b),
        .err(err_b), .err_cnt(err_cnt_b)
    );

    // Behavioural counters, one per instance; the transition table is the counter's state chart.
    always @(posedge clk) begin
        if (mode == 2) ctr_a <= 3'b010;
        else if (cnt_load_a) begin ctr_a <= cnt_load_value_a; adv_a <= 1'b0; end
        else if (cnt_en_a && !(mode == 1 && adv_a)) begin ctr_a <= nxt_tab[ctr_a]; adv_a <= 1'b1; end
    end
    always @(posedge clk) begin
        if (mode == 2) ctr_b <= 3'b010;
        else if (cnt_load_b) begin ctr_b <= cnt_load_value_b; adv_b <= 1'b0; end
        else if (cnt_en_b && !(mode == 1 && adv_b)) begin ctr_b <= nxt_tab[ctr_b]; adv_b <= 1'b1; end
    end

    typedef struct {
        logic [2:0] result;
        int         err4;
        int         err2;
        int         steps;
        int         acc_edge;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] seed;
        int         steps;
        int         mode;
        logic [2:0] result;
        int         err4;
        int         err2;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] seed, input int steps);
        if_a.cmd_valid = v; if_a.cmd_seed = seed; if_a.cmd_steps = STEP_W'(steps);
        if_b.cmd_valid = v; if_b.cmd_seed = seed; if_b.cmd_steps = STEP_W'(steps);
    endtask

    // Returns one falling edge after the accepting rising edge (state LOAD).
    task automatic issue(input logic [2:0] seed, input int steps, output int acc_edge);
        int w = 0;
        while (!if_a.cmd_ready && w < 2000) begin @(negedge clk); w++; end
        check("ready_wait", int'(if_a.cmd_ready), 1);
        drive(1'b1, seed, steps);
        cur_seed = seed;
        acc_edge = cyc + 1;
        @(negedge clk);
        drive(1'b0, 3'b000, 0);
    endtask

    task automatic run_vec(input logic [2:0] seed, input int steps, input logic [2:0] res,
                           input int e4, input int e2, output int acc_edge);
        exp_t e;
        issue(seed, steps, acc_edge);
        e.result = res; e.err4 = e4; e.err2 = e2; e.steps = steps; e.acc_edge = acc_edge;
        sb.push_back(e);
        $display("cmd seed=%b steps=%0d mode=%0d accepted at edge %0d", seed, steps, mode, acc_edge);
    endtask

    task automatic drain(input int limit);
        int w = 0;
        while (sb.size() != 0 && w < limit) begin @(negedge clk); w++; end
        check("drain", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_a", int'(if_a.cmd_ready), 1);
        check("rst_ready_b", int'(if_b.cmd_ready), 1);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_load", int'(cnt_load_a), 0);
        check("rst_en", int'(cnt_en_a), 0);
        check("rst_load_value", int'(cnt_load_value_a), 0);
        check("rst_result", int'(result_a), 0);
        check("rst_err", int'(err_a), 0);
        check("rst_err_cnt", int'(err_cnt_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        check("rst_result_b", int'(result_b), 0);
        check("rst_err_cnt_b", int'(err_cnt_b), 0);
    endtask

    // Completion and load-strobe monitor; done is sampled at the edge after it appears.
    always @(negedge clk) begin
        if (rst_n && (done_a || done_b)) begin
            if (sb.size() == 0) begin
                check("spurious_done", int'({done_a, done_b}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_pair", int'({done_a, done_b}), 3);
                check("result_a", int'(result_a), int'(e.result));
                check("result_b", int'(result_b), int'(e.result));
                check("err_cnt_a", int'(err_cnt_a), e.err4);
                check("err_cnt_b", int'(err_cnt_b), e.err2);
                check("err_a", int'(err_a), int'(e.err4 != 0));
                check("err_b", int'(err_b), int'(e.err2 != 0));
                check("done_latency", cyc + 1 - e.acc_edge, e.steps + 3);
                $display("done result=%b err_cnt_a=%0d err_cnt_b=%0d", result_a, err_cnt_a, err_cnt_b);
            end
        end
        if (rst_n && cnt_load_a) begin
            check("load_value", int'(cnt_load_value_a), int'(cur_seed));
            check("load_en_excl", int'(cnt_en_a), 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2;
        nxt_tab = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b010, 3'b111, 3'b000, 3'b100};
        //        seed    steps mode result err4 err2
        vt[0] = '{3'b100,   3,  0, 3'b111,  0, 0};
        vt[1] = '{3'b110,   2,  0, 3'b111,  0, 0};
        vt[2] = '{3'b110,   0,  0, 3'b110,  0, 0};
        vt[3] = '{3'b011,   5,  0, 3'b101,  0, 0};
        vt[4] = '{3'b001,   1,  0, 3'b111,  0, 0};
        vt[5] = '{3'b111, 255,  0, 3'b101,  0, 0};
        vt[6] = '{3'b100,   4,  1, 3'b010,  3, 3};
        vt[7] = '{3'b100,   8,  2, 3'b010,  7, 3};
        vt[8] = '{3'b000,   0,  2, 3'b010,  1, 1};
        vt[9] = '{3'b010,  24,  2, 3'b010, 15, 3};

        drive(1'b0, 3'b000, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            mode = vt[i].mode;
            run_vec(vt[i].seed, vt[i].steps, vt[i].result, vt[i].err4, vt[i].err2, acc1);
            drain(vt[i].steps + 20);
        end

        // Abort in the second RUN cycle: previous-run status (010, 15/3) must be held.
        issue(3'b100, 10, acc1);
        @(negedge clk);
        check("run_busy", int'(busy_a), 1);
        check("run_en", int'(cnt_en_a), 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy_a), 0);
        check("abort_ready", int'(if_a.cmd_ready), 1);
        check("abort_en", int'(cnt_en_a), 0);
        check("abort_result", int'(result_a), 3'b010);
        check("abort_err_cnt_a", int'(err_cnt_a), 15);
        check("abort_err_cnt_b", int'(err_cnt_b), 3);
        mode = 0;
        run_vec(3'b110, 0, 3'b110, 0, 0, acc1);
        drain(30);

        // Commands offered while busy are ignored.
        run_vec(3'b011, 6, 3'b111, 0, 0, acc1);
        drive(1'b1, 3'b000, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("busy_ready", int'(if_a.cmd_ready), 0);
        end
        drive(1'b0, 3'b000, 0);
        drain(30);
        repeat (8) @(negedge clk);

        // Back-to-back: the next command is taken in the cycle after done.
        run_vec(3'b100, 1, 3'b010, 0, 0, acc1);
        run_vec(3'b010, 2, 3'b111, 0, 0, acc2);
        check("b2b_accept", acc2 - acc1, 1 + 4);
        drain(30);

        // Reset in the middle of a run.
        issue(3'b101, 10, acc1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(3'b101, 2, 3'b100, 0, 0, acc1);
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
